fsm_equiv_sequencer: RTL

Test sequencer that drives one serial input stream into two state machines under comparison, an original machine (A) and its state-reduced equivalent (B), and checks that their outputs agree cycle by cycle. It puts both machines in reset, applies up to MAX_LEN input bits LSB-first, and captures each machine's output bit per cycle. It reports the first cycle on which the outputs differ. It sits between the board/bench control logic and the two machine instances, and owns their shared `x` and reset lines.

---
 rtl/fsm_equiv_pkg.sv | 18 +
 rtl/fsm_equiv_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fsm_equiv_pkg.sv
// -----------------------------------------------------------------------------
// fsm_equiv_pkg
// Shared definitions for the FSM equivalence sequencer.
//   MAX_LEN_DEFAULT : default stimulus length / response register width.
//   seq_state_t     : sequencer state encoding {IDLE, RST, RUN, DONE}.
// -----------------------------------------------------------------------------
package fsm_equiv_pkg;

    localparam int MAX_LEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_t;

endpackage : fsm_equiv_pkg

// File: rtl/fsm_equiv_sequencer.sv
// -----------------------------------------------------------------------------
// fsm_equiv_sequencer
// Drives one serial stimulus stream into two machines under comparison
// (original A and reduced B), captures both output streams and records the
// first cycle on which they disagree.
//
// Ports
//   clk          : clock, all state updates on the rising edge.
//   reset        : synchronous active-high reset.
//   start        : run request, sampled only in IDLE.
//   pattern      : stimulus bits, bit k applied on run cycle k.
//   len          : number of bits to apply, clamped to MAX_LEN.
//   y_a, y_b     : outputs of machine A and machine B.
//   x_out        : serial input shared by both machines.
//   fsm_reset    : reset shared by both machines (high for one cycle in RST).
//   busy         : high from RST through DONE.
//   done         : one-cycle pulse in DONE.
//   resp_a/resp_b: captured outputs, bit k from run cycle k.
//   mismatch     : sticky, outputs differed on at least one run cycle.
//   mismatch_idx : run cycle of the first difference, 0 when none.
// -----------------------------------------------------------------------------
module fsm_equiv_sequencer
    import fsm_equiv_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int IDX_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [IDX_W-1:0]   len,
    input  logic               y_a,
    input  logic               y_b,
    output logic               x_out,
    output logic               fsm_reset,
    output logic               busy,
    output logic               done,
    output logic [MAX_LEN-1:0] resp_a,
    output logic [MAX_LEN-1:0] resp_b,
    output logic               mismatch,
    output logic [IDX_W-1:0]   mismatch_idx
);

    // idx never exceeds MAX_LEN-1 while it is used as a bit select, so the
    // select only needs enough bits to address MAX_LEN positions.
    localparam int SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    seq_state_t         state_q,        state_d;
    logic [MAX_LEN-1:0] pattern_q,      pattern_d;
    logic [IDX_W-1:0]   len_q,          len_d;
    logic [IDX_W-1:0]   idx_q,          idx_d;
    logic [MAX_LEN-1:0] resp_a_q,       resp_a_d;
    logic [MAX_LEN-1:0] resp_b_q,       resp_b_d;
    logic               mismatch_q,     mismatch_d;
    logic [IDX_W-1:0]   mismatch_idx_q, mismatch_idx_d;

    logic [SEL_W-1:0]   sel;
    logic [IDX_W-1:0]   len_clamped;
    logic               last_bit;

    assign sel         = idx_q[SEL_W-1:0];
    assign len_clamped = (len > IDX_W'(MAX_LEN)) ? IDX_W'(MAX_LEN) : len;
    // Only consulted in RUN, where len_q >= 1, so the subtraction cannot wrap.
    assign last_bit    = (idx_q == (len_q - IDX_W'(1)));

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every *_d gets a hold value first so no path through the case
        // leaves a variable unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        pattern_d      = pattern_q;
        len_d          = len_q;
        idx_d          = idx_q;
        resp_a_d       = resp_a_q;
        resp_b_d       = resp_b_q;
        mismatch_d     = mismatch_q;
        mismatch_idx_d = mismatch_idx_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pattern_d      = pattern;
                    len_d          = len_clamped;
                    idx_d          = '0;
                    resp_a_d       = '0;
                    resp_b_d       = '0;
                    mismatch_d     = 1'b0;
                    mismatch_idx_d = '0;
                    state_d        = RST;
                end
            end
            RST: begin
                state_d = (len_q != '0) ? RUN : DONE;
            end
            RUN: begin
                // Mealy machines: y_a/y_b already reflect this cycle's x_out.
                resp_a_d[sel] = y_a;
                resp_b_d[sel] = y_b;
                if ((y_a != y_b) && !mismatch_q) begin
                    mismatch_d     = 1'b1;
                    mismatch_idx_d = idx_q;
                end
                idx_d = idx_q + IDX_W'(1);
                if (last_bit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs decoded from the state register
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state_q != IDLE);
        fsm_reset = (state_q == RST);
        done      = (state_q == DONE);
        x_out     = (state_q == RUN) ? pattern_q[sel] : 1'b0;
    end

    assign resp_a       = resp_a_q;
    assign resp_b       = resp_b_q;
    assign mismatch     = mismatch_q;
    assign mismatch_idx = mismatch_idx_q;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (reset) begin
            state_q        <= IDLE;
            // NOTE: the pattern and response registers are plain flops that
            // feed outputs directly, so they are cleared like any other state.
            pattern_q      <= '0;
            len_q          <= '0;
            idx_q          <= '0;
            resp_a_q       <= '0;
            resp_b_q       <= '0;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            pattern_q      <= pattern_d;
            len_q          <= len_d;
            idx_q          <= idx_d;
            resp_a_q       <= resp_a_d;
            resp_b_q       <= resp_b_d;
            mismatch_q     <= mismatch_d;
            mismatch_idx_q <= mismatch_idx_d;
        end
    end

endmodule : fsm_equiv_sequencer
